// File: rtl/clk_div_gen.sv
// Multi-channel programmable clock divider with per-period tick enables.
// Optional feature macro: CLK_DIV_SYNC_EN adds the sync_pulse phase-align input.
module clk_div_gen #(
  parameter int  CH_NUM  = 4,
  parameter int  DIV_W   = 8,
  parameter int  DIV_RST = 2,
  localparam int CH_W    = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_vld,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [DIV_W-1:0]  cfg_div,
  output logic              cfg_rdy,
  input  logic [CH_NUM-1:0] ch_en,
`ifdef CLK_DIV_SYNC_EN
  input  logic              sync_pulse,
`endif
  output logic [CH_NUM-1:0] clk_out,
  output logic [CH_NUM-1:0] tick,
  output logic [CH_NUM-1:0] busy
);

  localparam int             CH_P  = 2 ** CH_W;
  localparam logic [DIV_W-1:0] ONE   = 1;
  localparam logic [DIV_W:0]   ONE_X = 1;

  typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;

  logic             sync;
  logic [CH_P-1:0]  busy_pad;
  logic [DIV_W-1:0] cfg_div_n;

`ifdef CLK_DIV_SYNC_EN
  assign sync = sync_pulse;
`else
  assign sync = 1'b0;
`endif

  // Unused channel indices read as never busy, so out-of-range requests are
  // accepted and simply match no channel.
  assign busy_pad  = CH_P'(busy);
  assign cfg_rdy   = !rst && !busy_pad[cfg_ch];
  assign cfg_div_n = (cfg_div == '0) ? ONE : cfg_div;

  for (genvar g = 0; g < CH_NUM; g++) begin : g_ch
    state_t           st, nxt_st;
    logic [DIV_W-1:0] cnt, div, pend, nxt_cnt, nxt_div;
    logic [DIV_W:0]   hi_len;
    logic             busy_q, tick_q, clk_q;
    logic             nxt_busy, wrap, apply, take;

    assign take   = cfg_vld && cfg_rdy && (cfg_ch == CH_W'(g));
    assign wrap   = (cnt == div - ONE);
    assign hi_len = ({1'b0, nxt_div} + ONE_X) >> 1;

    // NOTE: every output of this block gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
      nxt_st  = st;
      nxt_cnt = cnt;
      apply   = 1'b0;
      case (st)
        IDLE: begin
          nxt_cnt = '0;
          apply   = busy_q;
          if (ch_en[g]) nxt_st = RUN;
        end
        default: begin
          if (sync) begin
            nxt_cnt = '0;
            apply   = busy_q;
            nxt_st  = ch_en[g] ? RUN : STOP;
          end else begin
            nxt_cnt = wrap ? '0 : cnt + ONE;
            apply   = wrap && busy_q;
            // A disable seen on the last cycle of a period ends it right there.
            if (ch_en[g])  nxt_st = RUN;
            else if (wrap) nxt_st = IDLE;
            else           nxt_st = STOP;
          end
        end
      endcase
      nxt_div  = apply ? pend : div;
      nxt_busy = (busy_q && !apply) || take;
    end

    // NOTE: clocked blocks use non-blocking assignments only, so every register
    // samples the pre-edge values and simulation order cannot matter.
    always_ff @(posedge clk) begin
      if (rst) begin
        st     <= IDLE;
        cnt    <= '0;
        div    <= DIV_W'(DIV_RST);
        busy_q <= 1'b0;
        tick_q <= 1'b0;
        clk_q  <= 1'b0;
      end else begin
        st     <= nxt_st;
        cnt    <= nxt_cnt;
        div    <= nxt_div;
        busy_q <= nxt_busy;
        tick_q <= (nxt_st != IDLE) && (nxt_cnt == '0);
        clk_q  <= (nxt_st != IDLE) && ({1'b0, nxt_cnt} < hi_len);
      end
    end

    // NOTE: pend is deliberately left out of reset; it is only read while
    // busy_q is set, and busy_q itself is reset.
    always_ff @(posedge clk) begin
      if (take) pend <= cfg_div_n;
    end

    assign tick[g]    = tick_q;
    assign clk_out[g] = clk_q;
    assign busy[g]    = busy_q;
  end

endmodule

// File: tb/tb_clk_div_gen.sv
// Self-checking bench for clk_div_gen: directed scenarios plus a randomized run
// against a period/position reference model.
module tb_clk_div_gen;

  localparam int CH_NUM  = 6;
  localparam int DIV_W   = 8;
  localparam int DIV_RST = 2;
  localparam int CH_W    = 3;

  logic              clk     = 1'b0;
  logic              rst     = 1'b1;
  logic              cfg_vld = 1'b0;
  logic [CH_W-1:0]   cfg_ch  = '0;
  logic [DIV_W-1:0]  cfg_div = '0;
  logic              cfg_rdy;
  logic [CH_NUM-1:0] ch_en   = '0;
  logic [CH_NUM-1:0] clk_out, tick, busy;
  logic              sync_in = 1'b0;

  int checks = 0;
  int errors = 0;

  // Reference model: is the channel producing periods, where in the period it
  // is, how long the period is, and the pending ratio (-1 when none).
  int m_act  [CH_NUM];
  int m_pos  [CH_NUM];
  int m_per  [CH_NUM];
  int m_pend [CH_NUM];

  always #5 clk = ~clk;

  clk_div_gen #(.CH_NUM(CH_NUM), .DIV_W(DIV_W), .DIV_RST(DIV_RST)) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_vld   (cfg_vld),
    .cfg_ch    (cfg_ch),
    .cfg_div   (cfg_div),
    .cfg_rdy   (cfg_rdy),
    .ch_en     (ch_en),
`ifdef CLK_DIV_SYNC_EN
    .sync_pulse(sync_in),
`endif
    .clk_out   (clk_out),
    .tick      (tick),
    .busy      (busy)
  );

  function automatic logic [CH_NUM-1:0] exp_tick();
    logic [CH_NUM-1:0] v;
    for (int i = 0; i < CH_NUM; i++) v[i] = (m_act[i] != 0) && (m_pos[i] == 0);
    return v;
  endfunction

  function automatic logic [CH_NUM-1:0] exp_clk();
    logic [CH_NUM-1:0] v;
    for (int i = 0; i < CH_NUM; i++) v[i] = (m_act[i] != 0) && (m_pos[i] < (m_per[i] + 1) / 2);
    return v;
  endfunction

  function automatic logic [CH_NUM-1:0] exp_busy();
    logic [CH_NUM-1:0] v;
    for (int i = 0; i < CH_NUM; i++) v[i] = (m_pend[i] >= 0);
    return v;
  endfunction

  function automatic logic exp_rdy();
    if (rst) return 1'b0;
    if (int'(cfg_ch) >= CH_NUM) return 1'b1;
    return m_pend[int'(cfg_ch)] < 0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < CH_NUM; i++) begin
      m_act[i]  = 0;
      m_pos[i]  = 0;
      m_per[i]  = DIV_RST;
      m_pend[i] = -1;
    end
  endtask

  task automatic apply_pend(input int i);
    if (m_pend[i] >= 0) begin
      m_per[i]  = m_pend[i];
      m_pend[i] = -1;
    end
  endtask

  task automatic model_step();
    logic take;
    take = cfg_vld && exp_rdy();
    if (rst) begin
      model_reset();
      return;
    end
    for (int i = 0; i < CH_NUM; i++) begin
      if (m_act[i] == 0) begin
        apply_pend(i);
        if (ch_en[i]) begin
          m_act[i] = 1;
          m_pos[i] = 0;
        end
      end else if (sync_in) begin
        m_pos[i] = 0;
        apply_pend(i);
      end else if (m_pos[i] == m_per[i] - 1) begin
        m_pos[i] = 0;
        apply_pend(i);
        if (!ch_en[i]) m_act[i] = 0;
      end else begin
        m_pos[i]++;
      end
    end
    if (take && int'(cfg_ch) < CH_NUM)
      m_pend[int'(cfg_ch)] = (cfg_div == '0) ? 1 : int'(cfg_div);
  endtask

  // One clock: DUT and model both consume the inputs driven before the edge.
  task automatic step();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    ch_en = '0;
    step();
    step();
    #1;
    checks++;
    if (cfg_rdy !== 1'b0) begin
      errors++; $display("FAIL reset_rdy: cfg_rdy=%b expected 0", cfg_rdy);
    end
    checks++;
    if ({tick, clk_out, busy} !== '0) begin
      errors++; $display("FAIL reset_outputs: tick=%b clk_out=%b busy=%b expected all 0", tick, clk_out, busy);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (cfg_rdy !== 1'b1) begin
      errors++; $display("FAIL reset_release_rdy: cfg_rdy=%b expected 1", cfg_rdy);
    end
  endtask

  task automatic test_basic();
    ch_en = 6'b000001;
    for (int k = 0; k < 8; k++) begin
      step();
      checks++;
      if (tick[0] !== (k % 2 == 0) || clk_out[0] !== (k % 2 == 0) ||
          tick[CH_NUM-1:1] !== '0 || clk_out[CH_NUM-1:1] !== '0) begin
        errors++; $display("FAIL basic cyc%0d: tick=%b clk_out=%b expected ch0 phase %0d", k, tick, clk_out, k % 2);
      end
      checks++;
      if ({tick, clk_out, busy} !== {exp_tick(), exp_clk(), exp_busy()}) begin
        errors++; $display("FAIL basic_model cyc%0d: got %b/%b/%b expected %b/%b/%b", k, tick, clk_out, busy, exp_tick(), exp_clk(), exp_busy());
      end
    end
    cfg_ch = 3'd0;
    #1;
    checks++;
    if (cfg_rdy !== 1'b1) begin
      errors++; $display("FAIL basic_rdy: cfg_rdy=%b expected 1", cfg_rdy);
    end
  endtask

  task automatic test_ratio_change();
    ch_en[1] = 1'b1;
    step();
    cfg_vld = 1'b1; cfg_ch = 3'd1; cfg_div = 8'd5;
    #1;
    checks++;
    if (cfg_rdy !== 1'b1) begin
      errors++; $display("FAIL ratio_rdy_idle: cfg_rdy=%b expected 1", cfg_rdy);
    end
    step();
    cfg_vld = 1'b0;
    #1;
    checks++;
    if (cfg_rdy !== 1'b0 || busy[1] !== 1'b1) begin
      errors++; $display("FAIL ratio_busy: cfg_rdy=%b busy[1]=%b expected 0/1", cfg_rdy, busy[1]);
    end
    step();
    for (int k = 0; k < 10; k++) begin
      checks++;
      if (clk_out[1] !== (k % 5 < 3) || tick[1] !== (k % 5 == 0) || busy[1] !== 1'b0) begin
        errors++; $display("FAIL ratio_period cyc%0d: clk_out[1]=%b tick[1]=%b busy[1]=%b expected %b/%b/0", k, clk_out[1], tick[1], busy[1], k % 5 < 3, k % 5 == 0);
      end
      checks++;
      if ({tick, clk_out, busy} !== {exp_tick(), exp_clk(), exp_busy()}) begin
        errors++; $display("FAIL ratio_model cyc%0d: got %b/%b/%b expected %b/%b/%b", k, tick, clk_out, busy, exp_tick(), exp_clk(), exp_busy());
      end
      step();
    end
  endtask

  task automatic test_stop_restart();
    bit en_s [12] = '{1, 1, 0, 0, 0, 0, 1, 1, 0, 1, 1, 1};
    bit tk_s [12] = '{1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0};
    bit ck_s [12] = '{1, 1, 0, 0, 0, 0, 1, 1, 0, 0, 1, 1};
    cfg_vld = 1'b1; cfg_ch = 3'd2; cfg_div = 8'd4;
    step();
    cfg_vld = 1'b0;
    step();
    for (int k = 0; k < 12; k++) begin
      ch_en[2] = en_s[k];
      step();
      checks++;
      if (tick[2] !== tk_s[k] || clk_out[2] !== ck_s[k]) begin
        errors++; $display("FAIL stop cyc%0d: tick[2]=%b clk_out[2]=%b expected %b/%b", k, tick[2], clk_out[2], tk_s[k], ck_s[k]);
      end
      checks++;
      if ({tick, clk_out, busy} !== {exp_tick(), exp_clk(), exp_busy()}) begin
        errors++; $display("FAIL stop_model cyc%0d: got %b/%b/%b expected %b/%b/%b", k, tick, clk_out, busy, exp_tick(), exp_clk(), exp_busy());
      end
    end
  endtask

  task automatic test_div_zero_and_bad_ch();
    cfg_vld = 1'b1; cfg_ch = 3'd3; cfg_div = 8'd0;
    step();
    cfg_vld = 1'b0;
    step();
    ch_en[3] = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      checks++;
      if (tick[3] !== 1'b1 || clk_out[3] !== 1'b1) begin
        errors++; $display("FAIL div0 cyc%0d: tick[3]=%b clk_out[3]=%b expected 1/1", k, tick[3], clk_out[3]);
      end
    end
    cfg_vld = 1'b1; cfg_ch = 3'd7; cfg_div = 8'd9;
    #1;
    checks++;
    if (cfg_rdy !== 1'b1) begin
      errors++; $display("FAIL bad_ch_rdy: cfg_rdy=%b expected 1", cfg_rdy);
    end
    step();
    cfg_vld = 1'b0;
    checks++;
    if (busy !== '0 || {tick, clk_out} !== {exp_tick(), exp_clk()}) begin
      errors++; $display("FAIL bad_ch_effect: busy=%b tick=%b clk_out=%b expected 0/%b/%b", busy, tick, clk_out, exp_tick(), exp_clk());
    end
  endtask

  task automatic test_reset_mid();
    cfg_vld = 1'b1; cfg_ch = 3'd0; cfg_div = 8'd7;
    step();
    cfg_vld = 1'b0;
    checks++;
    if (busy[0] !== 1'b1) begin
      errors++; $display("FAIL rstmid_pending: busy[0]=%b expected 1", busy[0]);
    end
    rst = 1'b1;
    step();
    #1;
    checks++;
    if ({tick, clk_out, busy} !== '0 || cfg_rdy !== 1'b0) begin
      errors++; $display("FAIL rstmid_outputs: tick=%b clk_out=%b busy=%b cfg_rdy=%b expected all 0", tick, clk_out, busy, cfg_rdy);
    end
    ch_en = 6'b000001;
    rst   = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      checks++;
      if (tick[0] !== (k % 2 == 0) || clk_out[0] !== (k % 2 == 0)) begin
        errors++; $display("FAIL rstmid_div cyc%0d: tick[0]=%b clk_out[0]=%b expected %b", k, tick[0], clk_out[0], k % 2 == 0);
      end
    end
  endtask

`ifdef CLK_DIV_SYNC_EN
  task automatic test_sync();
    ch_en = '0;
    rst   = 1'b1;
    step();
    rst = 1'b0;
    cfg_vld = 1'b1; cfg_ch = 3'd0; cfg_div = 8'd3;
    step();
    cfg_ch = 3'd1; cfg_div = 8'd6;
    step();
    cfg_vld = 1'b0;
    step();
    ch_en = 6'b000001;
    step();
    step();
    ch_en = 6'b000011;
    for (int k = 0; k < 4; k++) step();
    sync_in = 1'b1;
    step();
    sync_in = 1'b0;
    for (int k = 0; k < 12; k++) begin
      checks++;
      if (tick[0] !== (k % 3 == 0) || tick[1] !== (k % 6 == 0)) begin
        errors++; $display("FAIL sync cyc%0d: tick[1:0]=%b expected %b%b", k, tick[1:0], k % 6 == 0, k % 3 == 0);
      end
      checks++;
      if ({tick, clk_out, busy} !== {exp_tick(), exp_clk(), exp_busy()}) begin
        errors++; $display("FAIL sync_model cyc%0d: got %b/%b/%b expected %b/%b/%b", k, tick, clk_out, busy, exp_tick(), exp_clk(), exp_busy());
      end
      step();
    end
  endtask
`endif

  task automatic test_random();
    for (int k = 0; k < 3000; k++) begin
      for (int i = 0; i < CH_NUM; i++)
        if ($urandom_range(0, 15) == 0) ch_en[i] = ~ch_en[i];
      cfg_vld = ($urandom_range(0, 3) == 0);
      cfg_ch  = CH_W'($urandom_range(0, 7));
      cfg_div = ($urandom_range(0, 9) == 0) ? DIV_W'($urandom_range(0, 40)) : DIV_W'($urandom_range(0, 6));
      rst     = ($urandom_range(0, 499) == 0);
`ifdef CLK_DIV_SYNC_EN
      sync_in = ($urandom_range(0, 24) == 0);
`endif
      #1;
      checks++;
      if (cfg_rdy !== exp_rdy()) begin
        errors++; $display("FAIL rand_rdy cyc%0d: cfg_rdy=%b expected %b", k, cfg_rdy, exp_rdy());
      end
      step();
      checks++;
      if ({tick, clk_out, busy} !== {exp_tick(), exp_clk(), exp_busy()}) begin
        errors++; $display("FAIL rand cyc%0d: got %b/%b/%b expected %b/%b/%b", k, tick, clk_out, busy, exp_tick(), exp_clk(), exp_busy());
      end
    end
    cfg_vld = 1'b0;
    rst     = 1'b0;
    sync_in = 1'b0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_basic();
    test_ratio_change();
    test_stop_restart();
    test_div_zero_and_bad_ch();
    test_reset_mid();
`ifdef CLK_DIV_SYNC_EN
    test_sync();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
